// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcode constants and immediate-format helpers
package rv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  // Map a major opcode onto the immediate layout it carries
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: fmt = IMM_I;
      STORE:                      fmt = IMM_S;
      BRANCH:                     fmt = IMM_B;
      LUI, AUIPC:                 fmt = IMM_U;
      JAL:                        fmt = IMM_J;
      default:                    fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational RV32I immediate extraction and sign extension
module rv_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir_i,
  output logic [XLEN-1:0] imm_o
);
  import rv_pkg::*;

  imm_fmt_e           fmt;
  logic signed [31:0] imm32;

  assign fmt = imm_fmt_of(ir_i[6:0]);

  // Reassemble the scattered immediate bits; every format is signed from IR[31]
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
      IMM_S:   imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      IMM_B:   imm32 = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      IMM_U:   imm32 = {ir_i[31:12], 12'h000};
      IMM_J:   imm32 = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN keeping the sign (a no-op at XLEN=32)
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/rv_fetch_decode_pipe.sv
// rtl/rv_fetch_decode_pipe.sv - two-stage fetch/decode front end with stall, redirect and WB bypass
module rv_fetch_decode_pipe #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSN = rv_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_a,
  output logic [XLEN-1:0] id_ex_b,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_npc,
  output logic [31:0]     id_ex_ir,
  output logic [4:0]      id_ex_rd
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;

  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_ir_q, ifid_ir_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_npc_q, ifid_npc_d;

  logic            idex_valid_q, idex_valid_d;
  logic [XLEN-1:0] idex_a_q, idex_a_d;
  logic [XLEN-1:0] idex_b_q, idex_b_d;
  logic [XLEN-1:0] idex_imm_q, idex_imm_d;
  logic [XLEN-1:0] idex_pc_q, idex_pc_d;
  logic [XLEN-1:0] idex_npc_q, idex_npc_d;
  logic [31:0]     idex_ir_q, idex_ir_d;
  logic [4:0]      idex_rd_q, idex_rd_d;

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      rs1, rs2;
  logic            load_decode;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign rs1      = ifid_ir_q[19:15];
  assign rs2      = ifid_ir_q[24:20];

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir_i  (ifid_ir_q),
    .imm_o (dec_imm)
  );

  // Operand read: x0 is hard zero, a matching write-back beats the register file
  always_comb begin
    op_a = rf_rd1;
    op_b = rf_rd2;
    if (rs1 == 5'd0)                         op_a = '0;
    else if (wb_we && wb_rd == rs1)          op_a = wb_data;
    if (rs2 == 5'd0)                         op_b = '0;
    else if (wb_we && wb_rd == rs2)          op_b = wb_data;
  end

  // PC and IF/ID next state: redirect beats stall beats fetch
  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_npc_d   = ifid_npc_q;
    if (redirect_valid) begin
      pc_d         = redirect_pc & ~XLEN'(3);
      ifid_valid_d = 1'b0;
      ifid_ir_d    = NOP_INSN;
      ifid_pc_d    = '0;
      ifid_npc_d   = '0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (imem_valid) begin
      pc_d         = pc_plus4;
      ifid_valid_d = 1'b1;
      ifid_ir_d    = imem_rdata;
      ifid_pc_d    = pc_q;
      ifid_npc_d   = pc_plus4;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_ir_d    = NOP_INSN;
      ifid_pc_d    = '0;
      ifid_npc_d   = '0;
    end
  end

  // ID/EX next state: decode a live IF/ID entry, otherwise insert a bubble
  assign load_decode = !redirect_valid && !stall && ifid_valid_q;

  always_comb begin
    idex_valid_d = 1'b0;
    idex_a_d     = '0;
    idex_b_d     = '0;
    idex_imm_d   = '0;
    idex_pc_d    = '0;
    idex_npc_d   = '0;
    idex_ir_d    = NOP_INSN;
    idex_rd_d    = '0;
    if (load_decode) begin
      idex_valid_d = 1'b1;
      idex_a_d     = op_a;
      idex_b_d     = op_b;
      idex_imm_d   = dec_imm;
      idex_pc_d    = ifid_pc_q;
      idex_npc_d   = ifid_npc_q;
      idex_ir_d    = ifid_ir_q;
      idex_rd_d    = ifid_ir_q[11:7];
    end
  end

  // Pipeline state; reset drops every in-flight instruction at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= NOP_INSN;
      ifid_pc_q    <= '0;
      ifid_npc_q   <= '0;
      idex_valid_q <= 1'b0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      idex_pc_q    <= '0;
      idex_npc_q   <= '0;
      idex_ir_q    <= NOP_INSN;
      idex_rd_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_npc_q   <= ifid_npc_d;
      idex_valid_q <= idex_valid_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_imm_q   <= idex_imm_d;
      idex_pc_q    <= idex_pc_d;
      idex_npc_q   <= idex_npc_d;
      idex_ir_q    <= idex_ir_d;
      idex_rd_q    <= idex_rd_d;
    end
  end

  assign imem_addr   = pc_q;
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;
  assign id_ex_valid = idex_valid_q;
  assign id_ex_a     = idex_a_q;
  assign id_ex_b     = idex_b_q;
  assign id_ex_imm   = idex_imm_q;
  assign id_ex_pc    = idex_pc_q;
  assign id_ex_npc   = idex_npc_q;
  assign id_ex_ir    = idex_ir_q;
  assign id_ex_rd    = idex_rd_q;

endmodule
